// File: rtl/ipbus_reg_slave.sv
// IPbus register slave with read/write control registers and read-only status registers.
// Each transaction is followed by a programmable number of wait states and a one-cycle registered response.
module ipbus_reg_slave #(
    parameter int N_CTRL      = 4,
    parameter int N_STAT      = 4,
    parameter int ADDR_BITS   = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            ipb_addr,
    input  logic [31:0]            ipb_wdata,
    input  logic                   ipb_strobe,
    input  logic                   ipb_write,
    output logic [31:0]            ipb_rdata,
    output logic                   ipb_ack,
    output logic                   ipb_err,
    output logic [N_CTRL*32-1:0]   ctrl_out,
    output logic [N_CTRL-1:0]      ctrl_wr_stb,
    input  logic [N_STAT*32-1:0]   stat_in,
    output logic [15:0]            txn_count
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [ADDR_BITS-1:0]   lat_addr;
    logic                   lat_write;
    logic [31:0]            lat_wdata;

    logic [31:0]            cur_addr;
    logic                   cur_write;
    logic [31:0]            cur_wdata;
    logic                   commit;
    logic                   is_ctrl;
    logic                   is_stat;
    logic [31:0]            rd_word;

    // Only the low address bits are decoded; the rest are deliberately ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ipb_addr;

    // With no wait states the response is decided from the live bus, otherwise from the latched request.
    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can infer a latch.
        cur_addr  = 32'(lat_addr);
        cur_write = lat_write;
        cur_wdata = lat_wdata;
        commit    = 1'b0;
        if (state == S_IDLE) begin
            cur_addr  = 32'(ipb_addr[ADDR_BITS-1:0]);
            cur_write = ipb_write;
            cur_wdata = ipb_wdata;
            commit    = ipb_strobe && (WAIT_CYCLES == 0);
        end else if (state == S_WAIT) begin
            commit    = ipb_strobe && (wait_cnt == 4'd1);
        end
        is_ctrl = cur_addr < 32'(N_CTRL);
        is_stat = !is_ctrl && (cur_addr < 32'(N_CTRL + N_STAT));
        rd_word = '0;
        for (int k = 0; k < N_CTRL; k++)
            if (cur_addr == 32'(k)) rd_word = ctrl_out[k*32 +: 32];
        for (int k = 0; k < N_STAT; k++)
            if (cur_addr == 32'(N_CTRL + k)) rd_word = stat_in[k*32 +: 32];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wait_cnt    <= '0;
            lat_addr    <= '0;
            lat_write   <= 1'b0;
            lat_wdata   <= '0;
            ipb_rdata   <= '0;
            ipb_ack     <= 1'b0;
            ipb_err     <= 1'b0;
            ctrl_out    <= '0;
            ctrl_wr_stb <= '0;
            txn_count   <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            ipb_ack     <= 1'b0;
            ipb_err     <= 1'b0;
            ipb_rdata   <= '0;
            ctrl_wr_stb <= '0;
            case (state)
                S_IDLE: begin
                    if (ipb_strobe) begin
                        lat_addr  <= ipb_addr[ADDR_BITS-1:0];
                        lat_write <= ipb_write;
                        lat_wdata <= ipb_wdata;
                        wait_cnt  <= 4'(WAIT_CYCLES);
                        state     <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!ipb_strobe) begin
                        state    <= S_IDLE;
                        wait_cnt <= '0;
                    end else if (wait_cnt == 4'd1) begin
                        state    <= S_RESP;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                S_RESP: begin
                    state     <= S_IDLE;
                    txn_count <= txn_count + 16'd1;
                end
                default: state <= S_IDLE;
            endcase

            if (commit) begin
                if (is_ctrl && cur_write) begin
                    ipb_ack <= 1'b1;
                    for (int k = 0; k < N_CTRL; k++) begin
                        if (cur_addr == 32'(k)) begin
                            ctrl_out[k*32 +: 32] <= cur_wdata;
                            ctrl_wr_stb[k]       <= 1'b1;
                        end
                    end
                end else if ((is_ctrl || is_stat) && !cur_write) begin
                    ipb_ack   <= 1'b1;
                    ipb_rdata <= rd_word;
                end else begin
                    ipb_err   <= 1'b1;
                end
            end
        end
    end

endmodule
